// File: rtl/glitch_pkg.sv
//------------------------------------------------------------------------------
// Module   : glitch_pkg
// Brief    : Shared state encoding and default widths for glitch_delay_timer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package glitch_pkg;

    localparam int c_width_default = 16;
    localparam int c_pw_default    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sat_down_counter.sv
//------------------------------------------------------------------------------
// Module   : sat_down_counter
// Brief    : Loadable down-counter that stops at zero instead of wrapping.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sat_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/glitch_delay_timer.sv
//------------------------------------------------------------------------------
// Module   : glitch_delay_timer
// Brief    : Trigger-to-glitch timer: arm, wait for trigger, count delay down,
//            emit one pulse, strobe done. GLITCH_REARM_EN: DONE returns to ARMED.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module glitch_delay_timer
    import glitch_pkg::*;
#(
    parameter int WIDTH = c_width_default,
    parameter int PW    = c_pw_default
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic [WIDTH-1:0] delay_val,
    input  logic [PW-1:0]    pulse_len,
    input  logic             trigger,
    input  logic             abort,
    output logic             glitch_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    state_t           r_state;
    state_t           w_state_n;
    logic             r_glitch;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_dly_q;
    logic [PW-1:0]    r_plen_q;

    logic             w_glitch_n;
    logic             w_done_n;
    logic             w_busy_n;
    logic             w_latch;
    logic             w_dload;
    logic [WIDTH-1:0] w_dload_val;
    logic             w_den;
    logic             w_dzero;
    logic             w_pload;
    logic             w_pen;
    logic             w_pzero;
    logic [PW-1:0]    w_pcnt;

    sat_down_counter #(.W(WIDTH)) u_delay_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_dload),
        .load_val (w_dload_val),
        .en       (w_den),
        .count    (count),
        .zero     (w_dzero)
    );

    sat_down_counter #(.W(PW)) u_pulse_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_pload),
        .load_val (r_plen_q),
        .en       (w_pen),
        .count    (w_pcnt),
        .zero     (w_pzero)
    );

    // Only IDLE takes a fresh delay from the port; re-arming reuses the latched copy.
    assign w_dload_val = (r_state == ST_IDLE) ? delay_val : r_dly_q;

    always_comb begin
        w_state_n  = r_state;
        w_glitch_n = r_glitch;
        w_done_n   = 1'b0;
        w_latch    = 1'b0;
        w_dload    = 1'b0;
        w_den      = 1'b0;
        w_pload    = 1'b0;
        w_pen      = 1'b0;

        if (abort) begin
            w_state_n  = ST_IDLE;
            w_glitch_n = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        w_state_n = ST_ARMED;
                        w_latch   = 1'b1;
                        w_dload   = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (trigger) begin
                        w_state_n = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (!w_dzero) begin
                        w_den = 1'b1;
                    end else if (r_plen_q != '0) begin
                        w_state_n  = ST_PULSE;
                        w_glitch_n = 1'b1;
                        w_pload    = 1'b1;
                    end else begin
                        w_state_n = ST_DONE;
                        w_done_n  = 1'b1;
                    end
                end
                ST_PULSE: begin
                    // The zero term is a safety net; pcnt normally ends at 1.
                    if ((w_pcnt == PW'(1)) || w_pzero) begin
                        w_state_n  = ST_DONE;
                        w_glitch_n = 1'b0;
                        w_done_n   = 1'b1;
                    end else begin
                        w_pen = 1'b1;
                    end
                end
                ST_DONE: begin
`ifdef GLITCH_REARM_EN
                    w_state_n = ST_ARMED;
                    w_dload   = 1'b1;
`else
                    w_state_n = ST_IDLE;
`endif
                end
                default: begin
                    w_state_n  = ST_IDLE;
                    w_glitch_n = 1'b0;
                end
            endcase
        end

        w_busy_n = (w_state_n != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_glitch <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dly_q  <= '0;
            r_plen_q <= '0;
        end else begin
            r_state  <= w_state_n;
            r_glitch <= w_glitch_n;
            r_busy   <= w_busy_n;
            r_done   <= w_done_n;
            if (w_latch) begin
                r_dly_q  <= delay_val;
                r_plen_q <= pulse_len;
            end
        end
    end

    assign glitch_out = r_glitch;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_glitch_delay_timer.sv
//------------------------------------------------------------------------------
// Module   : tb_glitch_delay_timer
// Brief    : Directed, table-driven bench for glitch_delay_timer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_glitch_delay_timer;

`ifdef GLITCH_REARM_EN
    localparam bit REARM = 1'b1;
`else
    localparam bit REARM = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        arm;
    logic [15:0] delay_val;
    logic [7:0]  pulse_len;
    logic        trigger;
    logic        abort;
    logic        glitch_out;
    logic        busy;
    logic        done;
    logic [15:0] count;

    int n_vec  = 0;
    int n_fail = 0;
    bit busy_seen_low;

    typedef struct {
        bit          arm;
        logic [15:0] dval;
        logic [7:0]  plen;
        bit          trig;
        bit          abrt;
        bit          eg;
        bit          eb;
        bit          ed;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[$];

    glitch_delay_timer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm        (arm),
        .delay_val  (delay_val),
        .pulse_len  (pulse_len),
        .trigger    (trigger),
        .abort      (abort),
        .glitch_out (glitch_out),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input bit a, input int d, input int p, input bit t,
                                input bit ab, input bit eg, input bit eb, input bit ed,
                                input int ec);
        vec_t v;
        v.arm  = a;
        v.dval = 16'(d);
        v.plen = 8'(p);
        v.trig = t;
        v.abrt = ab;
        v.eg   = eg;
        v.eb   = eb;
        v.ed   = ed;
        v.ec   = 16'(ec);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!busy) busy_seen_low = 1'b1;
    endtask

    // Called just after the trigger edge E0: edges until glitch rises, then its width.
    task automatic measure(input int bound, output int rise, output int width, output bit done_at_fall);
        rise  = 0;
        width = 0;
        while (!glitch_out && rise < bound) begin
            step();
            rise++;
        end
        while (glitch_out && width < bound) begin
            step();
            width++;
        end
        done_at_fall = done;
    endtask

    task automatic idle_inputs();
        arm       = 1'b0;
        delay_val = '0;
        pulse_len = '0;
        trigger   = 1'b0;
        abort     = 1'b0;
    endtask

    initial begin
        int  rise;
        int  width;
        bit  dflag;
        bit  saw_glitch;
        bit  saw_done;

        rst_n = 1'b0;
        idle_inputs();
        #3;
        chk("reset glitch", glitch_out, 0);
        chk("reset busy",   busy,       0);
        chk("reset done",   done,       0);
        chk("reset count",  count,      0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post-reset busy", busy, 0);

        // Basic D=5 P=3, with arm/trigger pokes while busy
        tbl.push_back(mk(1, 5, 3, 0, 0, 0, 1, 0, 5));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 4));
        tbl.push_back(mk(1, 99, 9, 0, 0, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, REARM, 0, REARM ? 5 : 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, REARM ? 5 : 0));
        // Zero delay, one-cycle pulse
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, REARM, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        // No pulse, trigger held high throughout
        tbl.push_back(mk(1, 4, 0, 0, 0, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, REARM, 0, REARM ? 4 : 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, REARM, 0, REARM ? 4 : 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, REARM ? 4 : 0));

        for (int i = 0; i < tbl.size(); i++) begin
            arm       = tbl[i].arm;
            delay_val = tbl[i].dval;
            pulse_len = tbl[i].plen;
            trigger   = tbl[i].trig;
            abort     = tbl[i].abrt;
            step();
            chk($sformatf("v%0d glitch", i), glitch_out, tbl[i].eg);
            chk($sformatf("v%0d busy",   i), busy,       tbl[i].eb);
            chk($sformatf("v%0d done",   i), done,       tbl[i].ed);
            chk($sformatf("v%0d count",  i), count,      tbl[i].ec);
        end
        idle_inputs();
        step();

        // Abort in DELAY at count=100
        arm = 1'b1; delay_val = 16'd200; pulse_len = 8'd5;
        step();
        idle_inputs();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        saw_glitch = 1'b0;
        saw_done   = 1'b0;
        repeat (100) begin
            step();
            if (glitch_out) saw_glitch = 1'b1;
            if (done) saw_done = 1'b1;
        end
        chk("abort pre count", count, 100);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort busy",  busy,       0);
        chk("abort count", count,      100);
        chk("abort glitch", glitch_out, 0);
        chk("abort done",  done,       0);
        repeat (6) begin
            step();
            if (glitch_out) saw_glitch = 1'b1;
            if (done) saw_done = 1'b1;
        end
        chk("abort no glitch", saw_glitch, 0);
        chk("abort no done",   saw_done,   0);

        // Asynchronous reset mid-pulse
        arm = 1'b1; delay_val = 16'd2; pulse_len = 8'd10;
        step();
        idle_inputs();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        repeat (3) step();
        chk("pre-reset glitch", glitch_out, 1);
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst glitch", glitch_out, 0);
        chk("async rst busy",   busy,       0);
        chk("async rst count",  count,      0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("after rst busy", busy, 0);

        // Extremes D=0xFFFF, P=255
        arm = 1'b1; delay_val = 16'hFFFF; pulse_len = 8'd255;
        step();
        idle_inputs();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        measure(70000, rise, width, dflag);
        chk("max delay rise", rise,  65536);
        chk("max pulse width", width, 255);
        chk("max done at fall", dflag, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Re-arm behaviour: second trigger after completion
        busy_seen_low = 1'b0;
        arm = 1'b1; delay_val = 16'd3; pulse_len = 8'd2;
        step();
        idle_inputs();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        measure(20, rise, width, dflag);
        chk("rearm 1st rise",  rise,  4);
        chk("rearm 1st width", width, 2);
        chk("rearm 1st done",  dflag, 1);
        trigger = 1'b1;
        step();
        step();
        trigger = 1'b0;
        measure(20, rise, width, dflag);
        chk("rearm 2nd rise",  rise,  REARM ? 4 : 20);
        chk("rearm 2nd width", width, REARM ? 2 : 0);
        chk("rearm 2nd done",  dflag, REARM ? 1 : 0);
        chk("rearm busy low seen", busy_seen_low, REARM ? 0 : 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("final busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/glitch_delay_timer.md
Name: glitch_delay_timer

Overview:
- Trigger-to-glitch timing engine; the counting complement of the saturating up-counter used for measurement.
- Arms with a delay and a pulse length, waits for an external trigger, then counts the delay down to zero.
- Emits a single glitch pulse of programmed length, then flags completion.
- Sits between the host/config registers and the glitch output driver.

Parameters:
- WIDTH, 16, width of the delay counter and of delay_val/count.
- PW, 8, width of pulse_len and of the internal pulse counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- arm  input  1  latches delay_val and pulse_len when in IDLE; ignored otherwise.
- delay_val  input  WIDTH  trigger-to-pulse delay, in cycles.
- pulse_len  input  PW  glitch width in cycles; 0 means no pulse.
- trigger  input  1  level-sampled; honoured only in ARMED.
- abort  input  1  returns to IDLE from any state; highest priority after reset.
- glitch_out  output  1  registered glitch pulse.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion strobe.
- count  output  WIDTH  current delay counter value.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; glitch_out, busy and done all 0.
  - count=0; latched delay and pulse registers=0.
- Priority at each edge: abort > state-specific action.
- Abort in any state:
  - next state=IDLE; glitch_out=0 next edge; done is not asserted; count holds its value.
- IDLE: arm=1 latches delay_val into count and pulse_len into plen_q; next state=ARMED.
- ARMED:
  - trigger=1 at edge E0 moves the block to DELAY; count keeps the latched value D.
  - arm while ARMED is ignored; no re-latch.
- DELAY:
  - count!=0: count<=count-1.
  - count==0 and plen_q!=0: enter PULSE, set glitch_out<=1, load pcnt<=plen_q.
  - count==0 and plen_q==0: enter DONE, done<=1.
  - count saturates at 0 and never wraps.
- PULSE:
  - pcnt==1: glitch_out<=0, done<=1, enter DONE.
  - otherwise pcnt<=pcnt-1.
- DONE: done deasserts on the next edge; next state=IDLE (or ARMED, see Optional Feature).
- Latency:
  - glitch_out rises at edge E0+D+1 and stays high exactly P cycles.
  - done is high for exactly one cycle, starting at the edge where glitch_out falls.
- Maximum values: D=2^WIDTH-1 and P=2^PW-1 both operate without overflow.
- trigger held high through the whole sequence does not retrigger.
- busy is a registered output, equal to (next state != IDLE).

Optional Feature:
- Macro: GLITCH_REARM_EN.
- Defined: DONE transitions to ARMED instead of IDLE.
  - count reloads from the latched delay; plen_q is retained.
  - busy stays high, and the next trigger repeats the same glitch.
  - Only abort returns the block to IDLE.
- Undefined: DONE→IDLE; a fresh arm is required for every glitch.

Decomposition:
- Package glitch_pkg:
  - state enum (IDLE, ARMED, DELAY, PULSE, DONE).
  - default WIDTH/PW constants.
- One natural sub-module: sat_down_counter.
  - Ports: load, load_val, en, count, zero.
  - Decrements when en is set and count is not 0; holds at 0.
  - Instantiated twice: once for the delay counter, once for the pulse counter.

Test Plan:
- Basic timing: arm with D=5, P=3, trigger pulse at E0 -> glitch_out high on edges E6..E8 (3 cycles), done high only after E9, busy low after E10.
- Zero delay: D=0, P=1 -> glitch_out high for 1 cycle starting at E1, done at E2.
- No pulse: P=0, D=4 -> glitch_out never rises; done at E5; count reaches 0 and holds.
- Mid-operation abort and reset:
  - abort asserted in DELAY with count=100 -> IDLE next edge, no glitch, no done.
  - repeat with rst_n low mid-PULSE -> glitch_out drops immediately, with no clock edge needed.
- Extremes and ignored inputs:
  - D=0xFFFF, P=255 -> exact 65536-cycle delay and 255-cycle pulse, no wrap.
  - arm and trigger toggled while busy are ignored.
- Re-arm (GLITCH_REARM_EN defined): two triggers -> two identical glitches, busy stays high throughout; undefined -> second trigger ignored, block stays in IDLE.
